// File: rtl/tiny_mux_pkg.sv
// Shared types and register map for the tiny design multiplexer.
package tiny_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Register offsets, indexed by wbs_adr_i[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CLKDIV = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // Field positions
  localparam int CTRL_SEL_LSB   = 0;
  localparam int CTRL_SEL_W     = 8;
  localparam int CTRL_EN_BIT    = 8;
  localparam int STATUS_ST_LSB  = 0;
  localparam int STATUS_ERR_BIT = 8;
  localparam int DIV_W          = 16;

  // Encoding of the state as reported in STATUS[1:0]
  function automatic logic [1:0] state_code(input state_e s);
    case (s)
      ST_RESET: return 2'd1;
      ST_RUN:   return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tiny_clk_div.sv
// Divided design clock: toggles every DIV+1 cycles; DIV is resampled at each toggle.
module tiny_clk_div
  import tiny_mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             clk_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;

  // Count to the active divisor, toggle and pick up any new divisor at the toggle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
      div_q <= div;
      clk_o <= 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_q <= '0;
      div_q <= div;
      clk_o <= ~clk_o;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tiny_design_mux.sv
// Multiplexes NUM_DESIGNS user designs onto fixed IO slices with a Wishbone control window.
module tiny_design_mux
  import tiny_mux_pkg::*;
#(
  parameter int          NUM_DESIGNS = 4,
  parameter int          IN_W        = 8,
  parameter int          OUT_W       = 8,
  parameter int          IN_LSB      = 8,
  parameter int          OUT_LSB     = 16,
  parameter int          IO_PADS     = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          RST_CYCLES  = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [IO_PADS-1:0]           io_in,
  output logic [IO_PADS-1:0]           io_out,
  output logic [IO_PADS-1:0]           io_oeb,
  output logic [IN_W-1:0]              des_in_o,
  input  logic [NUM_DESIGNS*OUT_W-1:0] des_out_i,
  output logic [NUM_DESIGNS-1:0]       des_ena_o,
  output logic                         des_clk_o,
  output logic                         des_rst_o
);

  localparam int CW = $clog2(RST_CYCLES);

  logic                  ack_q;
  logic [31:0]           dat_q;
  logic [CTRL_SEL_W-1:0] sel_q;
  logic                  en_q;
  logic [DIV_W-1:0]      div_reg;
  logic                  err_q;
  logic                  ctrl_wr_q;
  state_e                state_q, state_d;
  logic [CW-1:0]         rst_cnt_q;
  logic [NUM_DESIGNS-1:0] ena_q;
  logic [OUT_W-1:0]      out_q, out_sel;
  logic                  enter_rst, err_set, sel_ok;
  logic                  in_win, req, wr;
  logic [1:0]            reg_idx;
  logic [31:0]           rdata;
  logic                  div_clk;

  assign in_win  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // ack_q blocks a second accept while the master still holds stb
  assign req     = wbs_stb_i & wbs_cyc_i & in_win & ~ack_q;
  assign wr      = req & wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];
  assign sel_ok  = ({1'b0, sel_q} < 9'(NUM_DESIGNS));

  // Register read mux
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_CTRL: begin
        rdata[CTRL_SEL_LSB +: CTRL_SEL_W] = sel_q;
        rdata[CTRL_EN_BIT]                = en_q;
      end
      REG_CLKDIV: rdata[DIV_W-1:0] = div_reg;
      REG_STATUS: begin
        rdata[STATUS_ST_LSB +: 2] = state_code(state_q);
        rdata[STATUS_ERR_BIT]     = err_q;
      end
      REG_RSVD: rdata = '0;
      default:  rdata = '0;
    endcase
  end

  // Wishbone ack and read data, one cycle after accept; data is zero outside reads
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  // CTRL / CLKDIV writes with byte enables; a CTRL write is handed to the FSM next cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sel_q     <= '0;
      en_q      <= 1'b0;
      div_reg   <= '0;
      ctrl_wr_q <= 1'b0;
    end else begin
      ctrl_wr_q <= wr && (reg_idx == REG_CTRL);
      if (wr) begin
        case (reg_idx)
          REG_CTRL: begin
            if (wbs_sel_i[0]) sel_q <= wbs_dat_i[CTRL_SEL_LSB +: CTRL_SEL_W];
            if (wbs_sel_i[1]) en_q  <= wbs_dat_i[CTRL_EN_BIT];
          end
          REG_CLKDIV: begin
            if (wbs_sel_i[0]) div_reg[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) div_reg[15:8] <= wbs_dat_i[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky select error; a new set beats a simultaneous write-1-to-clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
    else if (wr && reg_idx == REG_STATUS && wbs_sel_i[1] && wbs_dat_i[STATUS_ERR_BIT])
      err_q <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: reset countdown, then CTRL writes override from any state.
  // An out-of-range select also drops to IDLE so a bad select never keeps a design live.
  always_comb begin
    state_d   = state_q;
    enter_rst = 1'b0;
    err_set   = 1'b0;
    if (state_q == ST_RESET && rst_cnt_q == '0) state_d = ST_RUN;
    if (ctrl_wr_q) begin
      if (!en_q) begin
        state_d = ST_IDLE;
      end else if (sel_ok) begin
        state_d   = ST_RESET;
        enter_rst = 1'b1;
      end else begin
        state_d = ST_IDLE;
        err_set = 1'b1;
      end
    end
  end

  // Reset countdown and latched one-hot select
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rst_cnt_q <= '0;
      ena_q     <= '0;
    end else if (enter_rst) begin
      rst_cnt_q <= CW'(RST_CYCLES - 1);
      ena_q     <= NUM_DESIGNS'(1) << sel_q;
    end else if (state_q == ST_RESET && rst_cnt_q != '0) begin
      rst_cnt_q <= rst_cnt_q - 1'b1;
    end
  end

  // AND-OR pick of the selected design's output slice
  always_comb begin
    out_sel = '0;
    for (int d = 0; d < NUM_DESIGNS; d++)
      if (ena_q[d]) out_sel |= des_out_i[d*OUT_W +: OUT_W];
  end

  // Output register, one cycle of latency from des_out_i
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) out_q <= '0;
    else          out_q <= out_sel;
  end

  tiny_clk_div u_clk_div (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   ((state_q == ST_IDLE) || enter_rst),
    .div   (div_reg),
    .clk_o (div_clk)
  );

  // FSM outputs and pad drive; design clock is gated off in IDLE
  always_comb begin
    io_out    = '0;
    io_oeb    = '1;
    des_ena_o = '0;
    des_clk_o = 1'b0;
    des_rst_o = 1'b1;
    case (state_q)
      ST_RESET: begin
        des_ena_o = ena_q;
        des_clk_o = div_clk;
      end
      ST_RUN: begin
        des_ena_o                  = ena_q;
        des_clk_o                  = div_clk;
        des_rst_o                  = 1'b0;
        io_out[OUT_LSB +: OUT_W]   = out_q;
        io_oeb[OUT_LSB +: OUT_W]   = '0;
      end
      default: ;
    endcase
  end

  assign des_in_o  = io_in[IN_LSB +: IN_W];
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  logic unused_bits;
  assign unused_bits = ^{io_in, wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

endmodule

// File: tb/tb_tiny_design_mux.sv
// Bench for tiny_design_mux: timestamp-based reference model plus directed literal checks.
module tb_tiny_design_mux;

  localparam int          NUM_DESIGNS = 4;
  localparam int          IN_W        = 8;
  localparam int          OUT_W       = 8;
  localparam int          IN_LSB      = 8;
  localparam int          OUT_LSB     = 16;
  localparam int          IO_PADS     = 38;
  localparam logic [31:0] BASE_ADDR   = 32'h3000_0000;
  localparam int          RST_CYCLES  = 16;

  localparam logic [31:0] A_CTRL   = BASE_ADDR + 32'h0;
  localparam logic [31:0] A_CLKDIV = BASE_ADDR + 32'h4;
  localparam logic [31:0] A_STATUS = BASE_ADDR + 32'h8;

  logic clk;
  logic wb_rst_i, wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic wbs_ack_o;
  logic [IO_PADS-1:0] io_in, io_out, io_oeb;
  logic [IN_W-1:0] des_in_o;
  logic [NUM_DESIGNS*OUT_W-1:0] des_out_i;
  logic [NUM_DESIGNS-1:0] des_ena_o;
  logic des_clk_o, des_rst_o;

  tiny_design_mux #(
    .NUM_DESIGNS(NUM_DESIGNS), .IN_W(IN_W), .OUT_W(OUT_W), .IN_LSB(IN_LSB),
    .OUT_LSB(OUT_LSB), .IO_PADS(IO_PADS), .BASE_ADDR(BASE_ADDR), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .des_in_o(des_in_o), .des_out_i(des_out_i), .des_ena_o(des_ena_o),
    .des_clk_o(des_clk_o), .des_rst_o(des_rst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit rand_io = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 reset, 2 run. Reset length and clock phase are tracked as
  // absolute cycle timestamps rather than counters.
  int          cyc = 0;
  bit          m_valid = 1'b0;
  int          m_mode, m_dsel, m_t_entry, m_next_tgl;
  logic [7:0]  m_sel;
  logic        m_en, m_err, m_pend, m_ack, m_clk;
  logic [15:0] m_div;
  logic [31:0] m_dat;
  logic [OUT_W-1:0] m_out;

  function automatic bit win(input logic [31:0] a);
    return a[31:4] == BASE_ADDR[31:4];
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return {23'd0, m_en, m_sel};
      2'd1:    return {16'd0, m_div};
      2'd2:    return {23'd0, m_err, 6'd0, 2'(m_mode)};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model_p
    logic [31:0] rd;
    logic        rq, eset, p_en, p_pend;
    logic [7:0]  p_sel;
    logic [15:0] p_div;
    int          p_mode;
    cyc++;
    if (wb_rst_i) begin
      m_mode = 0; m_sel = 0; m_en = 0; m_div = 0; m_err = 0; m_pend = 0;
      m_ack = 0; m_dat = 0; m_clk = 0; m_out = 0; m_dsel = 0;
      m_t_entry = 0; m_next_tgl = 0;
      m_valid = 1'b1;
    end else begin
      p_mode = m_mode; p_sel = m_sel; p_en = m_en; p_div = m_div; p_pend = m_pend;
      rq = wbs_stb_i && wbs_cyc_i && win(wbs_adr_i) && !m_ack;
      rd = m_read(wbs_adr_i[3:2]);
      m_out = des_out_i[m_dsel*OUT_W +: OUT_W];
      if (p_mode == 1 && cyc - m_t_entry >= RST_CYCLES) m_mode = 2;
      if (p_mode != 0 && cyc == m_next_tgl) begin
        m_clk = !m_clk;
        m_next_tgl = cyc + int'(p_div) + 1;
      end
      eset = 1'b0;
      if (p_pend) begin
        if (p_en && int'(p_sel) < NUM_DESIGNS) begin
          m_mode = 1; m_t_entry = cyc; m_dsel = int'(p_sel);
          m_clk = 0; m_next_tgl = cyc + int'(p_div) + 1;
        end else begin
          m_mode = 0; m_clk = 0;
          eset = p_en;
        end
      end
      m_pend = 1'b0;
      m_ack = rq;
      m_dat = (rq && !wbs_we_i) ? rd : 32'd0;
      if (rq && wbs_we_i) begin
        case (wbs_adr_i[3:2])
          2'd0: begin
            if (wbs_sel_i[0]) m_sel = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) m_en  = wbs_dat_i[8];
            m_pend = 1'b1;
          end
          2'd1: begin
            if (wbs_sel_i[0]) m_div[7:0]  = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) m_div[15:8] = wbs_dat_i[15:8];
          end
          2'd2: if (wbs_sel_i[1] && wbs_dat_i[8]) m_err = 1'b0;
          default: ;
        endcase
      end
      if (eset) m_err = 1'b1;
    end
  end

  // Every-cycle compare of DUT outputs against the model
  always @(negedge clk) begin : cmp_p
    logic [IO_PADS-1:0] e_out, e_oeb;
    logic [NUM_DESIGNS-1:0] e_ena;
    if (m_valid) begin
      e_out = '0; e_oeb = '1; e_ena = '0;
      if (m_mode == 2) begin
        e_out[OUT_LSB +: OUT_W] = m_out;
        e_oeb[OUT_LSB +: OUT_W] = '0;
      end
      if (m_mode != 0) e_ena[m_dsel] = 1'b1;
      chk("io_out", 64'(io_out), 64'(e_out));
      chk("io_oeb", 64'(io_oeb), 64'(e_oeb));
      chk("des_ena", 64'(des_ena_o), 64'(e_ena));
      chk("des_rst", 64'(des_rst_o), 64'(m_mode != 2));
      chk("des_clk", 64'(des_clk_o), 64'(m_mode != 0 && m_clk));
      chk("des_in", 64'(des_in_o), 64'(io_in[IN_LSB +: IN_W]));
      chk("wb_ack", 64'(wbs_ack_o), 64'(m_ack));
      chk("wb_dat", 64'(wbs_dat_o), 64'(m_dat));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output bit acked);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    acked = 1'b0; rd = '0;
    for (int n = 0; n < 4 && !acked; n++) begin
      tick();
      if (wbs_ack_o) begin acked = 1'b1; rd = wbs_dat_o; end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd; bit a;
    wb_xfer(1'b1, adr, dat, 4'hF, rd, a);
    chk("wr_ack", 64'(a), 64'd1);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
    bit a;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, d, a);
    chk("rd_ack", 64'(a), 64'd1);
  endtask

  task automatic rst_len(output int n);
    n = 0;
    while (des_rst_o !== 1'b0 && n < 64) begin tick(); n++; end
  endtask

  task automatic count_tgl(input int samples, output int t);
    logic prev;
    t = 0; prev = des_clk_o;
    for (int i = 1; i < samples; i++) begin
      tick();
      if (des_clk_o !== prev) t++;
      prev = des_clk_o;
    end
  endtask

  // Random pad and design-output activity
  initial forever begin
    @(posedge clk); #2;
    if (rand_io) begin
      io_in     = IO_PADS'({$urandom, $urandom});
      des_out_i = (NUM_DESIGNS*OUT_W)'($urandom);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    int n, t;
    wb_rst_i = 1'b1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    io_in = IO_PADS'(38'h15_C3A5_5A3C);
    des_out_i = 32'h77A5_3C11;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();

    // Reset state
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst_des_rst", 64'(des_rst_o), 64'd1);
    wb_rd(A_STATUS, d); chk("rst_status", 64'(d), 64'h0);
    wb_rd(A_CTRL, d);   chk("rst_ctrl", 64'(d), 64'h0);

    // Select design 2, DIV=0
    wb_wr(A_CTRL, 32'h102);
    rst_len(n); chk("rst_len_sel2", 64'(n), 64'(RST_CYCLES + 1));
    chk("ena_sel2", 64'(des_ena_o), 64'b0100);
    wb_rd(A_STATUS, d); chk("status_run", 64'(d), 64'h2);
    count_tgl(9, t); chk("clk_div0_tgl", 64'(t), 64'd8);

    // Output path: design 2 visible, design 1 not, one cycle of latency
    tick();
    chk("io_out_a5", 64'(io_out[OUT_LSB +: OUT_W]), 64'hA5);
    des_out_i = 32'h775A_3C11;
    chk("io_out_hold", 64'(io_out[OUT_LSB +: OUT_W]), 64'hA5);
    tick();
    chk("io_out_5a", 64'(io_out[OUT_LSB +: OUT_W]), 64'h5A);

    // Out-of-range select sets ERR and idles; write-1 clears
    wb_wr(A_CTRL, 32'h105);
    tick();
    wb_rd(A_STATUS, d); chk("status_err", 64'(d), 64'h100);
    chk("err_ena", 64'(des_ena_o), 64'd0);
    wb_wr(A_STATUS, 32'h100);
    wb_rd(A_STATUS, d); chk("status_clr", 64'(d), 64'h0);

    // DIV=3, reselect during RESET restarts the reset count
    wb_wr(A_CLKDIV, 32'h3);
    wb_wr(A_CTRL, 32'h102);
    repeat (3) tick();
    wb_wr(A_CTRL, 32'h101);
    rst_len(n); chk("rst_len_resel", 64'(n), 64'(RST_CYCLES + 1));
    chk("ena_sel1", 64'(des_ena_o), 64'b0010);
    count_tgl(17, t); chk("clk_div3_tgl", 64'(t), 64'd4);

    // Reset during RUN with a simultaneous CTRL write
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = A_CTRL; wbs_dat_i = 32'h103; wb_rst_i = 1'b1;
    tick();
    chk("rst_noack", 64'(wbs_ack_o), 64'd0);
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wb_rst_i = 1'b0;
    chk("rst2_des_rst", 64'(des_rst_o), 64'd1);
    chk("rst2_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst2_io_out", 64'(io_out), 64'd0);
    wb_rd(A_CTRL, d);   chk("rst2_ctrl", 64'(d), 64'h0);
    wb_rd(A_CLKDIV, d); chk("rst2_div", 64'(d), 64'h0);

    // Randomized traffic, checked by the model every cycle
    rand_io = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, wd, rd;
      logic [3:0]  bs;
      bit          acked;
      int          op;
      op = $urandom_range(0, 10);
      bs = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      case (op)
        0, 1, 2: begin
          wd = {23'd0, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 5))};
          wb_xfer(1'b1, A_CTRL, wd, bs, rd, acked);
          chk("rnd_ctrl_ack", 64'(acked), 64'd1);
        end
        3: begin
          wb_xfer(1'b1, A_CLKDIV, 32'($urandom_range(0, 3)), bs, rd, acked);
          chk("rnd_div_ack", 64'(acked), 64'd1);
        end
        4: begin
          wb_xfer(1'b1, A_STATUS, 32'($urandom_range(0, 1)) << 8, bs, rd, acked);
          chk("rnd_stat_ack", 64'(acked), 64'd1);
        end
        5, 6: begin
          a = BASE_ADDR + 32'($urandom_range(0, 3) * 4);
          wb_xfer(1'b0, a, 32'd0, 4'hF, rd, acked);
          chk("rnd_rd_ack", 64'(acked), 64'd1);
        end
        7: begin
          a = BASE_ADDR ^ (32'h1 << $urandom_range(4, 31));
          wb_xfer($urandom_range(0, 1) == 1, a, 32'h101, 4'hF, rd, acked);
          chk("oow_noack", 64'(acked), 64'd0);
        end
        8, 9: repeat ($urandom_range(1, 40)) tick();
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
          end else tick();
        end
      endcase
    end
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
